// File: rtl/ats21_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ats21_cmd_sequencer (with helper ats21_cmd_fifo)
// Description : Pairs client A/B instruction FIFO heads into one ATS21
//               req/ctrlA/ctrlB two-word transaction and returns stat/data.
// Revision    : 1.0 - initial release
// ============================================================================

module ats21_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] din,
    input  logic        pop,
    output logic [31:0] dout,
    output logic        empty,
    output logic        full
);
    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    logic [31:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr;
    logic [c_aw-1:0] r_rd;
    logic [c_aw:0]   r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (c_aw + 1)'(push) - (c_aw + 1)'(pop);
        end
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr] <= din;
    end

    assign dout  = r_mem[r_rd];
    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == c_depth);
endmodule

module ats21_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [31:0] a_instr,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_instr,
    output logic        b_ready,
    output logic        ats_req,
    output logic [15:0] ats_ctrlA,
    output logic [15:0] ats_ctrlB,
    input  logic        ats_ready,
    input  logic [1:0]  ats_stat,
    input  logic [23:0] ats_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_stat,
    output logic [23:0] rsp_data,
    output logic        rsp_tmo,
    output logic        rsp_a_nop,
    output logic        rsp_b_nop,
    output logic        busy
);
    localparam int              c_tw       = ($clog2(TIMEOUT) < 4) ? 4 : $clog2(TIMEOUT);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_WAIT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t          r_state;
    logic [31:0]     r_stg_a;
    logic [31:0]     r_stg_b;
    logic            r_nop_a;
    logic            r_nop_b;
    logic [c_tw-1:0] r_timer;

    logic            r_req;
    logic [15:0]     r_ctrl_a;
    logic [15:0]     r_ctrl_b;
    logic            r_rsp_valid;
    logic [1:0]      r_rsp_stat;
    logic [23:0]     r_rsp_data;
    logic            r_rsp_tmo;
    logic            r_rsp_a_nop;
    logic            r_rsp_b_nop;
    logic            r_busy;

    logic            w_push_a, w_push_b;
    logic            w_pop_a,  w_pop_b;
    logic            w_empty_a, w_empty_b;
    logic            w_full_a,  w_full_b;
    logic [31:0]     w_head_a,  w_head_b;

    assign a_ready  = !w_full_a;
    assign b_ready  = !w_full_b;
    assign w_push_a = a_valid && !w_full_a;
    assign w_push_b = b_valid && !w_full_b;
    assign w_pop_a  = (r_state == S_IDLE) && !w_empty_a;
    assign w_pop_b  = (r_state == S_IDLE) && !w_empty_b;

    ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_a),
        .din   (a_instr),
        .pop   (w_pop_a),
        .dout  (w_head_a),
        .empty (w_empty_a),
        .full  (w_full_a)
    );

    ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_b),
        .din   (b_instr),
        .pop   (w_pop_b),
        .dout  (w_head_b),
        .empty (w_empty_b),
        .full  (w_full_b)
    );

    // Outputs are assigned on the edge that enters each state, so they line
    // up cycle-exactly with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_stg_a     <= '0;
            r_stg_b     <= '0;
            r_nop_a     <= 1'b0;
            r_nop_b     <= 1'b0;
            r_timer     <= '0;
            r_req       <= 1'b0;
            r_ctrl_a    <= '0;
            r_ctrl_b    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_stat  <= '0;
            r_rsp_data  <= '0;
            r_rsp_tmo   <= 1'b0;
            r_rsp_a_nop <= 1'b0;
            r_rsp_b_nop <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty_a || !w_empty_b) begin
                        r_stg_a  <= w_empty_a ? 32'h0 : w_head_a;
                        r_stg_b  <= w_empty_b ? 32'h0 : w_head_b;
                        r_nop_a  <= w_empty_a;
                        r_nop_b  <= w_empty_b;
                        r_req    <= 1'b1;
                        r_ctrl_a <= '0;
                        r_ctrl_b <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_req    <= 1'b0;
                    r_ctrl_a <= r_stg_a[31:16];
                    r_ctrl_b <= r_stg_b[31:16];
                    r_state  <= S_HI;
                end
                S_HI: begin
                    r_ctrl_a <= r_stg_a[15:0];
                    r_ctrl_b <= r_stg_b[15:0];
                    r_timer  <= '0;
                    r_state  <= S_LO;
                end
                S_LO: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ats_ready || (r_timer == c_tmo_last)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_stat  <= ats_ready ? ats_stat : 2'b00;
                        r_rsp_data  <= ats_ready ? ats_data : 24'h0;
                        r_rsp_tmo   <= !ats_ready;
                        r_rsp_a_nop <= r_nop_a;
                        r_rsp_b_nop <= r_nop_b;
                        r_ctrl_a    <= '0;
                        r_ctrl_b    <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req    <= 1'b0;
                    r_ctrl_a <= '0;
                    r_ctrl_b <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign ats_req   = r_req;
    assign ats_ctrlA = r_ctrl_a;
    assign ats_ctrlB = r_ctrl_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_stat  = r_rsp_stat;
    assign rsp_data  = r_rsp_data;
    assign rsp_tmo   = r_rsp_tmo;
    assign rsp_a_nop = r_rsp_a_nop;
    assign rsp_b_nop = r_rsp_b_nop;
    assign busy      = r_busy;
endmodule

`default_nettype wire

// File: tb/tb_ats21_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ats21_cmd_sequencer
// Description : Scoreboard bench; a transaction-level model predicts FIFO
//               acceptance, pairing and response timing for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ats21_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [31:0] a_instr = '0, b_instr = '0;
    logic        ats_ready = 1'b0;
    logic [1:0]  ats_stat = '0;
    logic [23:0] ats_data = '0;
    logic        a_ready, b_ready, ats_req, rsp_valid, rsp_tmo, rsp_a_nop, rsp_b_nop, busy;
    logic [15:0] ats_ctrlA, ats_ctrlB;
    logic [1:0]  rsp_stat;
    logic [23:0] rsp_data;

    ats21_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_instr(a_instr), .a_ready(a_ready),
        .b_valid(b_valid), .b_instr(b_instr), .b_ready(b_ready),
        .ats_req(ats_req), .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
        .ats_ready(ats_ready), .ats_stat(ats_stat), .ats_data(ats_data),
        .rsp_valid(rsp_valid), .rsp_stat(rsp_stat), .rsp_data(rsp_data),
        .rsp_tmo(rsp_tmo), .rsp_a_nop(rsp_a_nop), .rsp_b_nop(rsp_b_nop),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          s;      // edge at which the heads are popped
        logic [31:0] a;
        logic [31:0] b;
        logic        anop;
        logic        bnop;
        int          w;      // number of WAIT cycles
        logic        tmo;
        logic [1:0]  stat;
        logic [23:0] data;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        plan_q[$];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int edge_no = 0, free_edge = 0, mode = 0;
    int n_checks = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: one step per active edge while reset is low. Pop uses contents
    // before this edge's pushes; a new transaction may start once the previous
    // one has had REQ,HI,LO,W*WAIT,RESP and one IDLE evaluation cycle.
    task automatic step();
        txn_t t;
        logic pa, pb;
        edge_no++;
        pa = a_valid && (qa.size() < DEPTH);
        pb = b_valid && (qb.size() < DEPTH);
        if (edge_no >= free_edge && (qa.size() > 0 || qb.size() > 0)) begin
            t.s    = edge_no;
            t.anop = (qa.size() == 0);
            t.bnop = (qb.size() == 0);
            t.a    = t.anop ? 32'h0 : qa.pop_front();
            t.b    = t.bnop ? 32'h0 : qb.pop_front();
            t.tmo  = 1'b0;
            t.stat = 2'($urandom);
            t.data = 24'($urandom);
            t.w    = 1;
            case (mode)
                0: if ($urandom_range(0, 5) == 0) begin t.tmo = 1'b1; t.w = TMO; end
                   else t.w = int'($urandom_range(1, TMO));
                2: begin t.tmo = 1'b1; t.w = TMO; end
                3: begin t.w = TMO; t.stat = 2'b10; t.data = 24'h00ABCD; end
                default: t.w = 1;
            endcase
            exp_q.push_back(t);
            plan_q.push_back(t);
            free_edge = edge_no + 5 + t.w;
        end
        if (pa) qa.push_back(a_instr);
        if (pb) qb.push_back(b_instr);
    endtask

    task automatic cyc(input logic av, input logic [31:0] ai, input logic bv, input logic [31:0] bi);
        @(negedge clk);
        a_valid = av; a_instr = ai; b_valid = bv; b_instr = bi;
        chk("a_ready", a_ready, qa.size() < DEPTH);
        chk("b_ready", b_ready, qb.size() < DEPTH);
        @(posedge clk);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || edge_no < free_edge) && n < 500) begin
            cyc(1'b0, 32'h0, 1'b0, 32'h0);
            n++;
        end
        chk("drain_within_budget", n < 500, 1'b1);
        idle(2);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {ats_req, ats_ctrlA, ats_ctrlB, rsp_valid, rsp_stat, rsp_data,
                   rsp_tmo, rsp_a_nop, rsp_b_nop, busy}, 64'h0);
        chk({name, "_ready"}, {a_ready, b_ready}, 2'b11);
    endtask

    // Release at negedge+1, then let the first post-reset edge be modelled.
    task automatic release_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        free_edge = edge_no + 1;
        @(posedge clk);
        step();
    endtask

    // ATS21 responder: raises ready in the planned WAIT cycle; junk otherwise.
    int   r_cnt = -1;
    txn_t rp;
    always @(negedge clk) begin
        if (reset) begin
            r_cnt = -1;
            ats_ready = 1'b0;
        end else begin
            ats_ready = 1'b0;
            ats_stat  = 2'($urandom);
            ats_data  = 24'($urandom);
            if (ats_req) begin
                if (plan_q.size() > 0) begin
                    rp = plan_q.pop_front();
                    r_cnt = 0;
                end
            end else if (r_cnt >= 0) begin
                r_cnt++;
            end
            if (r_cnt >= 0 && r_cnt == 2 + rp.w) begin
                if (!rp.tmo) begin
                    ats_ready = 1'b1;
                    ats_stat  = rp.stat;
                    ats_data  = rp.data;
                end
                r_cnt = -1;
            end
        end
    end

    // Monitor: k counts cycles since the req pulse of the transaction in flight.
    logic        inflight = 1'b0;
    int          k = 0, mcyc = 0, last_req = -100;
    txn_t        cur;
    logic [1:0]  l_stat = '0;
    logic [23:0] l_data = '0;
    logic        l_tmo = 1'b0, l_anop = 1'b0, l_bnop = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            inflight = 1'b0;
            last_req = -100;
            l_stat = '0; l_data = '0; l_tmo = 1'b0; l_anop = 1'b0; l_bnop = 1'b0;
        end else begin
            mcyc++;
            if (ats_req) begin
                chk("req_spacing_ge6", (mcyc - last_req) >= 6, 1'b1);
                chk("req_while_busy", inflight, 1'b0);
                last_req = mcyc;
                chk("req_has_pending_txn", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    inflight = 1'b1;
                    k = 0;
                    chk("req_edge", 64'(edge_no), 64'(cur.s));
                end
            end
            if (inflight) begin
                chk("busy_active", busy, 1'b1);
                if (k == 0) begin
                    chk("req_ctrl_zero", {ats_ctrlA, ats_ctrlB}, 32'h0);
                    chk("req_no_rsp", rsp_valid, 1'b0);
                end else if (k == 1) begin
                    chk("hi_req_low", ats_req, 1'b0);
                    chk("hi_words", {ats_ctrlA, ats_ctrlB}, {cur.a[31:16], cur.b[31:16]});
                end else if (k <= 2 + cur.w) begin
                    chk("lo_req_low", ats_req, 1'b0);
                    chk("lo_words", {ats_ctrlA, ats_ctrlB}, {cur.a[15:0], cur.b[15:0]});
                    chk("wait_no_rsp", rsp_valid, 1'b0);
                end else begin
                    l_stat = cur.tmo ? 2'b00 : cur.stat;
                    l_data = cur.tmo ? 24'h0 : cur.data;
                    l_tmo  = cur.tmo;
                    l_anop = cur.anop;
                    l_bnop = cur.bnop;
                    chk("rsp_valid", rsp_valid, 1'b1);
                    chk("rsp_fields", {rsp_stat, rsp_data, rsp_tmo, rsp_a_nop, rsp_b_nop},
                        {l_stat, l_data, l_tmo, l_anop, l_bnop});
                    chk("resp_ctrl_zero", {ats_ctrlA, ats_ctrlB}, 32'h0);
                    inflight = 1'b0;
                end
                k++;
            end else begin
                chk("idle_busy", busy, 1'b0);
                chk("idle_no_rsp", rsp_valid, 1'b0);
                chk("idle_ctrl_zero", {ats_ctrlA, ats_ctrlB}, 32'h0);
                chk("rsp_hold", {rsp_stat, rsp_data, rsp_tmo, rsp_a_nop, rsp_b_nop},
                    {l_stat, l_data, l_tmo, l_anop, l_bnop});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        release_reset();

        // Paired A/B push, ready on first WAIT cycle.
        mode = 1;
        cyc(1'b1, 32'h2080_0000, 1'b1, 32'h2240_0000);
        drain();

        // B only: A slot becomes a filler NOP.
        mode = 1;
        cyc(1'b0, 32'h0, 1'b1, 32'hA183_0010);
        drain();

        // Ready never comes: timeout response.
        mode = 2;
        cyc(1'b1, 32'h1234_5678, 1'b0, 32'h0);
        drain();

        // Ready on the timeout cycle itself wins; opcode 000 goes out verbatim.
        mode = 3;
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0001);
        drain();

        // Fill A's FIFO while a long transaction is outstanding.
        mode = 2;
        cyc(1'b1, 32'h5000_0000, 1'b0, 32'h0);
        idle(2);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h6000_0000 + 32'(i), 1'b0, 32'h0);
        mode = 0;
        drain();

        // Randomized traffic on both clients.
        mode = 0;
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0, $urandom);
        drain();

        // Reset in WAIT with two entries still queued in A.
        mode = 2;
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h7100_0000 + 32'(i), 1'b0, 32'h0);
        idle(3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midop_reset");
        qa.delete(); qb.delete(); exp_q.delete(); plan_q.delete();
        @(posedge clk);
        release_reset();
        idle(4);
        mode = 1;
        cyc(1'b1, 32'hC0DE_0001, 1'b1, 32'hC0DE_0002);
        drain();

        chk("all_txns_issued", exp_q.size(), 0);
        chk("no_txn_in_flight", inflight, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
